// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, word geometry and line type for the instruction cache.
package icache_pkg;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {IDLE, MISS, RESP, DRAIN} icache_state_e;

  typedef logic [WORD_W*WORDS_PER_LINE-1:0] line_t;
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: direct-mapped data/tag/valid arrays with combinational read,
// a single write port and a flush that clears only the valid bits.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  output line_t                    rd_line,
  output logic [TAG_W-1:0]         rd_tag,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic [TAG_W-1:0]         wr_tag,
  input  line_t                    wr_data,
  input  logic                     wr_valid,
  input  logic                     flush
);
  line_t              data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_data;
      tag_q[wr_idx]  <= wr_tag;
    end
  end

  // Flush wins over a same-cycle write so a refill racing a flush stays invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   valid_q <= '0;
    else if (flush) valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= wr_valid;
  end

  assign rd_line  = data_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache, one 128-bit line refill per miss.
// Define ICACHE_PERF_EN to add hit_cnt_out / miss_cnt_out performance counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 16,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned MEM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req_in,
  input  logic [ADDR_W-1:0]     fetch_addr_in,
  input  logic                  fetch_flush_in,
  output logic [WORD_W-1:0]     fetch_instr_out,
  output logic                  fetch_valid_out,
  output logic                  mem_req_out,
  output logic [MEM_ADDR_W-1:0] mem_addr_out,
  input  logic [LINE_W-1:0]     mem_data_in,
  input  logic                  mem_comp_in
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           hit_cnt_out,
  output logic [31:0]           miss_cnt_out
`endif
);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - 4 - IDX_W;

  icache_state_e         state_q, state_d;
  logic                  valid_q, valid_d;
  logic [WORD_W-1:0]     instr_q, instr_d;
  logic                  mem_req_q, mem_req_d;
  logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
  logic                  flush_pend_q, flush_pend_d;

  logic [1:0]            word;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  line_t                 rd_line;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid;
  logic                  hit;
  logic                  wr_en;
  logic                  wr_valid;
  logic                  unused_addr_lsb;

  assign word            = fetch_addr_in[3:2];
  assign idx             = fetch_addr_in[4 +: IDX_W];
  assign tag             = fetch_addr_in[ADDR_W-1:4+IDX_W];
  assign unused_addr_lsb = ^fetch_addr_in[1:0];
  assign hit             = rd_valid && (rd_tag == tag);

  icache_line_store #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_store (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (idx),
    .rd_line  (rd_line),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (mem_data_in),
    .wr_valid (wr_valid),
    .flush    (fetch_flush_in)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DRAIN;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      mem_req_q    <= 1'b0;
      maddr_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      mem_req_q    <= mem_req_d;
      maddr_q      <= maddr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = 1'b0;
    instr_d      = instr_q;
    mem_req_d    = mem_req_q;
    maddr_d      = maddr_q;
    flush_pend_d = flush_pend_q;
    wr_en        = 1'b0;
    wr_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (fetch_req_in) begin
          if (hit) begin
            instr_d = rd_line[32'(word)*WORD_W +: WORD_W];
            valid_d = 1'b1;
            state_d = RESP;
          end else begin
            mem_req_d = 1'b1;
            maddr_d   = MEM_ADDR_W'(fetch_addr_in[ADDR_W-1:4]);
            state_d   = MISS;
          end
        end
      end
      MISS: begin
        // A flush seen anywhere in the refill window leaves the refilled line invalid.
        if (fetch_flush_in) flush_pend_d = 1'b1;
        if (mem_comp_in) begin
          wr_en     = 1'b1;
          wr_valid  = !(fetch_flush_in || flush_pend_q);
          instr_d   = mem_data_in[32'(word)*WORD_W +: WORD_W];
          valid_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DRAIN;
        end
      end
      RESP:  state_d = IDLE;
      DRAIN: if (!mem_comp_in) state_d = IDLE;
      default: state_d = DRAIN;
    endcase
  end

  assign fetch_instr_out = instr_q;
  assign fetch_valid_out = valid_q;
  assign mem_req_out     = mem_req_q;
  assign mem_addr_out    = maddr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        lookup;

  assign lookup = (state_q == IDLE) && fetch_req_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup && hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;
`endif

  a_req_held_in_miss: assert property (
    @(posedge clk) disable iff (!reset_n) (state_q == MISS) |-> fetch_req_in
  );
endmodule
